// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of data_memory_interface: single-cycle stores,
// two-cycle loads, and rejection of misaligned or out-of-range accesses.

`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h0000_1000
`endif
`ifndef DATA_END
`define DATA_END 32'h0000_1FFC
`endif

package data_memory_arbiter_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FMT_W  = 3;

  typedef struct packed {
    logic              we;
    logic [FMT_W-1:0]  fmt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Address must lie in the data window and be naturally aligned for its size.
  function automatic logic access_legal(input logic [ADDR_W-1:0] addr,
                                        input logic [FMT_W-1:0]  fmt);
    logic in_range;
    logic aligned;
    in_range = (addr >= ADDR_W'(`DATA_BEGIN)) && (addr <= ADDR_W'(`DATA_END));
    case (fmt[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    return in_range && aligned;
  endfunction
endpackage

module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned RESET_PRIORITY = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [FMT_W-1:0]  m0_fmt,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [FMT_W-1:0]  m1_fmt,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [FMT_W-1:0]  mem_data_format,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_data_fetched
);

  typedef enum logic [0:0] {IDLE, READ} state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic               owner_q, owner_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [FMT_W-1:0]   fmt_q, fmt_d;
  logic               legal_q, legal_d;

  mem_req_t           req0, req1, win;
  logic               any_req;
  logic               win_id;
  logic               win_legal;
  logic [1:0]         gnt_v, rvalid_v, err_v;
  logic [DATA_W-1:0]  rdata0, rdata1;

  assign req0 = '{we: m0_we, fmt: m0_fmt, addr: m0_addr, wdata: m0_wdata};
  assign req1 = '{we: m1_we, fmt: m1_fmt, addr: m1_addr, wdata: m1_wdata};

  // Winner: a lone requester, or the priority holder when both ask.
  always_comb begin
    any_req   = m0_req | m1_req;
    win_id    = m1_req & (~m0_req | prio_q);
    win       = win_id ? req1 : req0;
    win_legal = access_legal(win.addr, win.fmt);
  end

  // State, priority and captured load context.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'(RESET_PRIORITY);
      owner_q <= 1'b0;
      addr_q  <= '0;
      fmt_q   <= '0;
      legal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      fmt_q   <= fmt_d;
      legal_q <= legal_d;
    end
  end

  // Next state, grants, responses and memory port drive.
  always_comb begin
    state_d          = state_q;
    prio_d           = prio_q;
    owner_d          = owner_q;
    addr_d           = addr_q;
    fmt_d            = fmt_q;
    legal_d          = legal_q;
    gnt_v            = '0;
    rvalid_v         = '0;
    err_v            = '0;
    rdata0           = '0;
    rdata1           = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_data_format  = '0;
    mem_address      = '0;
    mem_write_data   = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_v[win_id]   = 1'b1;
          prio_d          = ~win_id;
          mem_address     = win.addr;
          mem_data_format = win.fmt;
          if (win.we) begin
            if (win_legal) begin
              mem_write_enable = 1'b1;
              mem_write_data   = win.wdata;
            end else begin
              err_v[win_id] = 1'b1;
            end
          end else begin
            owner_d = win_id;
            addr_d  = win.addr;
            fmt_d   = win.fmt;
            legal_d = win_legal;
            state_d = READ;
          end
        end
      end
      READ: begin
        // Address and format held stable while the RAM returns data.
        mem_address       = addr_q;
        mem_data_format   = fmt_q;
        mem_read_enable   = legal_q;
        rvalid_v[owner_q] = 1'b1;
        if (!legal_q) begin
          err_v[owner_q] = 1'b1;
        end else if (owner_q) begin
          rdata1 = mem_data_fetched;
        end else begin
          rdata0 = mem_data_fetched;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // No handshake or memory strobe may escape while reset is held.
    if (reset) begin
      gnt_v            = '0;
      rvalid_v         = '0;
      err_v            = '0;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
    end
  end

  assign m0_gnt    = gnt_v[0];
  assign m1_gnt    = gnt_v[1];
  assign m0_rvalid = rvalid_v[0];
  assign m1_rvalid = rvalid_v[1];
  assign m0_err    = err_v[0];
  assign m1_err    = err_v[1];
  assign m0_rdata  = rdata0;
  assign m1_rdata  = rdata1;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model (round-robin winner, byte-array memory, access rules).

`ifndef DATA_BEGIN
`define DATA_BEGIN 32'h0000_1000
`endif
`ifndef DATA_END
`define DATA_END 32'h0000_1FFC
`endif

module tb_data_memory_arbiter;
  localparam logic [31:0] DB = `DATA_BEGIN;
  localparam logic [31:0] DE = `DATA_END;
  localparam int unsigned MEM_BYTES = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_fmt, m1_fmt;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read_enable, mem_write_enable;
  logic [2:0]  mem_data_format;
  logic [31:0] mem_address, mem_write_data, mem_data_fetched;
  logic        mem_clear;

  int errors;
  int checks;

  logic [7:0] dev_mem [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  always #5 clock = ~clock;

  data_memory_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_fmt(m0_fmt), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_fmt(m1_fmt), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_data_format(mem_data_format), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_data_fetched(mem_data_fetched)
  );

  function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] f);
    case (f[1:0])
      2'b00:   return f[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'b01:   return f[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Stand-in for data_memory_interface: formatted read, byte-lane write.
  always_comb begin : dev_read
    logic [31:0] raw;
    raw = '0;
    for (int k = 0; k < 4; k++)
      if (mem_address - DB + 32'(k) < 32'(MEM_BYTES))
        raw[8*k +: 8] = dev_mem[12'(mem_address - DB + 32'(k))];
    mem_data_fetched = mem_read_enable ? ext(raw, mem_data_format) : 32'h0;
  end

  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) dev_mem[12'(i)] <= 8'h00;
    end else if (mem_write_enable) begin
      for (int k = 0; k < 4; k++)
        if (32'(k) < (32'd1 << mem_data_format[1:0]) &&
            (mem_address - DB + 32'(k) < 32'(MEM_BYTES)))
          dev_mem[12'(mem_address - DB + 32'(k))] <= mem_write_data[8*k +: 8];
    end
  end

  function automatic bit legal_ref(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] sz;
    if (f[1:0] == 2'b11) return 1'b0;
    sz = 32'd1 << f[1:0];
    return (a >= DB) && (a <= DE) && ((a % sz) == 32'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] raw;
    logic [31:0] off;
    raw = '0;
    for (int k = 0; k < 4; k++) begin
      off = a - DB + 32'(k);
      if (off < 32'(MEM_BYTES)) raw[8*k +: 8] = ref_mem[off[11:0]];
    end
    return ext(raw, f);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    logic [31:0] off;
    for (int k = 0; k < (1 << f[1:0]); k++) begin
      off = a - DB + 32'(k);
      if (off < 32'(MEM_BYTES)) ref_mem[off[11:0]] = d[8*k +: 8];
    end
  endtask

  // Single request on one port; reports grant wait, grant-cycle and response-cycle observations.
  task automatic issue(input bit port, input bit we, input logic [2:0] fmt,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int wait_cyc, output bit g_err, output bit g_we,
                       output bit r_valid, output bit r_err, output logic [31:0] r_data,
                       output bit other_rv, output bit early_rv);
    wait_cyc = -1; g_err = 0; g_we = 0; r_valid = 0; r_err = 0; r_data = '0;
    other_rv = 0; early_rv = 0;
    if (port) begin
      m1_req = 1; m1_we = we; m1_fmt = fmt; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1; m0_we = we; m0_fmt = fmt; m0_addr = addr; m0_wdata = wdata;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (port ? m1_gnt : m0_gnt) begin
        wait_cyc = i;
        g_err    = port ? m1_err : m0_err;
        g_we     = mem_write_enable;
        early_rv = m0_rvalid | m1_rvalid;
        break;
      end
    end
    @(posedge clock); #1;
    m0_req = 0; m1_req = 0;
    if (!we && wait_cyc >= 0) begin
      @(negedge clock);
      r_valid  = port ? m1_rvalid : m0_rvalid;
      r_err    = port ? m1_err : m0_err;
      r_data   = port ? m1_rdata : m0_rdata;
      other_rv = port ? m0_rvalid : m1_rvalid;
    end
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    m0_req = 0; m1_req = 0; reset = 1;
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    m0_req = 1; m0_we = 1; m0_fmt = 3'b010; m0_addr = DB; m0_wdata = 32'h1111_2222;
    m1_req = 1; m1_we = 0; m1_fmt = 3'b010; m1_addr = DB;
    @(negedge clock);
    @(negedge clock);
    checks++; if ({m1_gnt, m0_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", {m1_gnt, m0_gnt}); end
    checks++; if ({mem_write_enable, mem_read_enable} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b want 00", {mem_write_enable, mem_read_enable}); end
    checks++; if ({m1_rvalid, m0_rvalid, m1_err, m0_err} !== 4'h0) begin errors++; $display("FAIL reset_resp: got %b want 0000", {m1_rvalid, m0_rvalid, m1_err, m0_err}); end
    @(posedge clock); #1;
    m0_req = 0; m1_req = 0; reset = 0; mem_clear = 0;
    @(negedge clock);
    checks++; if (mem_address !== 32'h0 || mem_write_data !== 32'h0 || mem_data_format !== 3'h0) begin errors++; $display("FAIL idle_mem_outputs: got addr=%h wdata=%h fmt=%b want zeros", mem_address, mem_write_data, mem_data_format); end
    checks++; if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid} !== 4'h0 || m0_rdata !== 0 || m1_rdata !== 0) begin errors++; $display("FAIL idle_outputs: got gnt/rv=%b rdata=%h/%h want zeros", {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata); end
    @(posedge clock); #1;
  endtask

  task automatic test_store_load();
    int w; bit ge, gwe, rv, re, orv, erv; logic [31:0] rd;
    issue(1'b0, 1'b1, 3'b010, DB + 8, 32'hDEADBEEF, w, ge, gwe, rv, re, rd, orv, erv);
    ref_store(DB + 8, 3'b010, 32'hDEADBEEF);
    checks++; if (w !== 0) begin errors++; $display("FAIL store_gnt_wait: got %0d want 0", w); end
    checks++; if (ge !== 1'b0) begin errors++; $display("FAIL store_err: got %b want 0", ge); end
    checks++; if (gwe !== 1'b1) begin errors++; $display("FAIL store_we: got %b want 1", gwe); end
    @(negedge clock);
    checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL store_we_pulse: got %b want 0", mem_write_enable); end
    @(posedge clock); #1;
    issue(1'b1, 1'b0, 3'b010, DB + 8, 32'h0, w, ge, gwe, rv, re, rd, orv, erv);
    checks++; if (w !== 0) begin errors++; $display("FAIL load_gnt_wait: got %0d want 0", w); end
    checks++; if (erv !== 1'b0) begin errors++; $display("FAIL load_rvalid_early: got %b want 0", erv); end
    checks++; if (rv !== 1'b1 || re !== 1'b0) begin errors++; $display("FAIL load_rvalid: got rv=%b err=%b want 1/0", rv, re); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
    checks++; if (orv !== 1'b0) begin errors++; $display("FAIL load_other_rvalid: got %b want 0", orv); end
  endtask

  task automatic test_alternate();
    bit nxt, own;
    logic [31:0] exp0, exp1;
    apply_reset();
    nxt = 1'b0;
    own = 1'b0;
    exp0 = ref_load(DB + 8, 3'b010);
    exp1 = ref_load(DB + 8, 3'b100);
    m0_req = 1; m0_we = 0; m0_fmt = 3'b010; m0_addr = DB + 8;
    m1_req = 1; m1_we = 0; m1_fmt = 3'b100; m1_addr = DB + 8;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (c % 2 == 0) begin
        checks++;
        if ({m1_gnt, m0_gnt} !== (nxt ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_gnt c=%0d: got %b want %b", c, {m1_gnt, m0_gnt}, nxt ? 2'b10 : 2'b01); end
        own = nxt;
        nxt = ~nxt;
      end else begin
        checks++;
        if ({m1_rvalid, m0_rvalid, m1_gnt, m0_gnt} !== (own ? 4'b1000 : 4'b0100)) begin errors++; $display("FAIL alt_resp c=%0d: got rv/gnt=%b want %b", c, {m1_rvalid, m0_rvalid, m1_gnt, m0_gnt}, own ? 4'b1000 : 4'b0100); end
        checks++;
        if ((own ? m1_rdata : m0_rdata) !== (own ? exp1 : exp0)) begin errors++; $display("FAIL alt_rdata c=%0d: got %h want %h", c, own ? m1_rdata : m0_rdata, own ? exp1 : exp0); end
      end
    end
    @(posedge clock); #1;
    m0_req = 0; m1_req = 0;
  endtask

  task automatic test_formats();
    int w; bit ge, gwe, rv, re, orv, erv; logic [31:0] rd;
    logic [2:0]  fmts [6] = '{3'b101, 3'b000, 3'b100, 3'b001, 3'b001, 3'b011};
    logic [31:0] offs [6] = '{32'd8, 32'd8, 32'd11, 32'd10, 32'd9, 32'd8};
    logic [31:0] want [6] = '{32'h0000BEEF, 32'hFFFFFFEF, 32'h000000DE, 32'hFFFFDEAD, 32'h0, 32'h0};
    bit          werr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 1'b0, fmts[i], DB + offs[i], 32'h0, w, ge, gwe, rv, re, rd, orv, erv);
      checks++; if (rv !== 1'b1 || re !== werr[i]) begin errors++; $display("FAIL fmt%0d_resp: got rv=%b err=%b want 1/%b", i, rv, re, werr[i]); end
      checks++; if (rd !== want[i]) begin errors++; $display("FAIL fmt%0d_rdata: got %h want %h", i, rd, want[i]); end
    end
  endtask

  task automatic test_out_of_range();
    int w; bit ge, gwe, rv, re, orv, erv; logic [31:0] rd;
    issue(1'b1, 1'b1, 3'b010, DE, 32'hCAFEF00D, w, ge, gwe, rv, re, rd, orv, erv);
    ref_store(DE, 3'b010, 32'hCAFEF00D);
    checks++; if (ge !== 1'b0 || gwe !== 1'b1) begin errors++; $display("FAIL end_store: got err=%b we=%b want 0/1", ge, gwe); end
    issue(1'b1, 1'b1, 3'b010, DE + 4, 32'h12345678, w, ge, gwe, rv, re, rd, orv, erv);
    checks++; if (w !== 0 || ge !== 1'b1) begin errors++; $display("FAIL oor_store_err: got wait=%0d err=%b want 0/1", w, ge); end
    checks++; if (gwe !== 1'b0) begin errors++; $display("FAIL oor_store_we: got %b want 0", gwe); end
    issue(1'b1, 1'b1, 3'b010, DE - 2, 32'h55555555, w, ge, gwe, rv, re, rd, orv, erv);
    checks++; if (ge !== 1'b1 || gwe !== 1'b0) begin errors++; $display("FAIL mis_store: got err=%b we=%b want 1/0", ge, gwe); end
    issue(1'b1, 1'b1, 3'b000, DB - 1, 32'h77, w, ge, gwe, rv, re, rd, orv, erv);
    checks++; if (ge !== 1'b1 || gwe !== 1'b0) begin errors++; $display("FAIL low_store: got err=%b we=%b want 1/0", ge, gwe); end
    issue(1'b1, 1'b0, 3'b010, DE, 32'h0, w, ge, gwe, rv, re, rd, orv, erv);
    checks++; if (rv !== 1'b1 || re !== 1'b0 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL end_readback: got rv=%b err=%b data=%h want 1/0/cafef00d", rv, re, rd); end
    issue(1'b1, 1'b0, 3'b010, DE + 4, 32'h0, w, ge, gwe, rv, re, rd, orv, erv);
    checks++; if (rv !== 1'b1 || re !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_load: got rv=%b err=%b data=%h want 1/1/0", rv, re, rd); end
  endtask

  task automatic test_reset_in_read();
    @(posedge clock); #1;
    m0_req = 1; m0_we = 0; m0_fmt = 3'b010; m0_addr = DB + 8;
    @(negedge clock);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rr_first_gnt: got %b want 1", m0_gnt); end
    @(posedge clock); #1;
    m0_req = 0; reset = 1;
    @(negedge clock);
    checks++; if ({m1_rvalid, m0_rvalid} !== 2'b00) begin errors++; $display("FAIL rr_rvalid_in_reset: got %b want 00", {m1_rvalid, m0_rvalid}); end
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    checks++; if ({m1_rvalid, m0_rvalid} !== 2'b00) begin errors++; $display("FAIL rr_rvalid_after: got %b want 00", {m1_rvalid, m0_rvalid}); end
    @(posedge clock); #1;
    m0_req = 1; m0_we = 0; m0_fmt = 3'b010; m0_addr = DB + 8;
    m1_req = 1; m1_we = 0; m1_fmt = 3'b101; m1_addr = DB + 8;
    @(negedge clock);
    checks++; if ({m1_gnt, m0_gnt} !== 2'b01) begin errors++; $display("FAIL rr_priority: got %b want 01", {m1_gnt, m0_gnt}); end
    @(posedge clock); #1;
    m0_req = 0;
    @(negedge clock);
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_gnt !== 1'b0) begin errors++; $display("FAIL rr_m0_resp: got rv=%b data=%h gnt1=%b want 1/deadbeef/0", m0_rvalid, m0_rdata, m1_gnt); end
    @(negedge clock);
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL rr_m1_gnt: got %b want 1", m1_gnt); end
    @(posedge clock); #1;
    m1_req = 0;
    @(negedge clock);
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL rr_m1_resp: got rv=%b data=%h want 1/0000beef", m1_rvalid, m1_rdata); end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return DE - 4 + 32'($urandom_range(0, 11));
      1:       return DB - 4 + 32'($urandom_range(0, 7));
      default: return DB + 32'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic test_random();
    bit          pend [2];
    bit          pwe  [2];
    logic [2:0]  pfmt [2];
    logic [31:0] paddr [2];
    logic [31:0] pwd  [2];
    bit busy, owner, last, w, lg, exp_er;
    logic [31:0] exp_rd, er0, er1;
    logic [1:0]  eg, erv, eer;
    bit          ewe;
    apply_reset();
    last = 1'b1; busy = 1'b0; owner = 1'b0; exp_er = 1'b0; exp_rd = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pwe[p] = 0; pfmt[p] = '0; paddr[p] = '0; pwd[p] = '0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          if ($urandom_range(0, 9) == 0) pend[p] = 0;
        end else if ($urandom_range(0, 9) < 7) begin
          pend[p] = 1; pwe[p] = 1'($urandom_range(0, 1)); pfmt[p] = 3'($urandom_range(0, 7));
          paddr[p] = rand_addr(); pwd[p] = $urandom;
        end
      end
      m0_req = pend[0]; m0_we = pwe[0]; m0_fmt = pfmt[0]; m0_addr = paddr[0]; m0_wdata = pwd[0];
      m1_req = pend[1]; m1_we = pwe[1]; m1_fmt = pfmt[1]; m1_addr = paddr[1]; m1_wdata = pwd[1];
      @(negedge clock);
      eg = '0; erv = '0; eer = '0; er0 = '0; er1 = '0; ewe = 0;
      if (busy) begin
        erv[owner] = 1'b1;
        eer[owner] = exp_er;
        if (owner) er1 = exp_rd; else er0 = exp_rd;
        busy = 0;
      end else if (pend[0] || pend[1]) begin
        w = (pend[0] && pend[1]) ? ~last : pend[1];
        last = w;
        eg[w] = 1'b1;
        lg = legal_ref(paddr[w], pfmt[w]);
        if (pwe[w]) begin
          eer[w] = ~lg;
          ewe = lg;
          if (lg) ref_store(paddr[w], pfmt[w], pwd[w]);
        end else begin
          busy = 1; owner = w; exp_er = ~lg;
          exp_rd = lg ? ref_load(paddr[w], pfmt[w]) : 32'h0;
        end
        pend[w] = 0;
      end
      checks++; if ({m1_gnt, m0_gnt} !== eg) begin errors++; $display("FAIL rnd_gnt cyc=%0d: got %b want %b", cyc, {m1_gnt, m0_gnt}, eg); end
      checks++; if ({m1_rvalid, m0_rvalid} !== erv) begin errors++; $display("FAIL rnd_rvalid cyc=%0d: got %b want %b", cyc, {m1_rvalid, m0_rvalid}, erv); end
      checks++; if ({m1_err, m0_err} !== eer) begin errors++; $display("FAIL rnd_err cyc=%0d: got %b want %b", cyc, {m1_err, m0_err}, eer); end
      checks++; if (m0_rdata !== er0 || m1_rdata !== er1) begin errors++; $display("FAIL rnd_rdata cyc=%0d: got %h/%h want %h/%h", cyc, m0_rdata, m1_rdata, er0, er1); end
      checks++; if (mem_write_enable !== ewe) begin errors++; $display("FAIL rnd_we cyc=%0d: got %b want %b", cyc, mem_write_enable, ewe); end
      @(posedge clock); #1;
    end
    m0_req = 0; m1_req = 0;
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1; mem_clear = 1;
    m0_req = 0; m0_we = 0; m0_fmt = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_fmt = '0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[12'(i)] = 8'h00;
    test_reset();
    test_store_load();
    test_alternate();
    test_formats();
    test_out_of_range();
    test_reset_in_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
